ps2_key_controller: RTL and testbench

PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_event_fifo.sv | 60 ++++++
 rtl/ps2_key_controller.sv | 135 +++++++++++++
 tb/tb_ps2_key_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 key controller shared definitions.
// Parser state encoding, prefix bytes and event layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam int         EV_W    = 10;

    function automatic logic [EV_W-1:0] make_ev(
        input logic       ext,
        input logic       rel,
        input logic [7:0] code
    );
        return {ext, rel, code};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Key-event FIFO: power-of-two depth, simultaneous push/pop.
// A push into a full FIFO is accepted only if a pop frees the head.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EV_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && full && !do_pop;
    assign count   = cnt;
    assign head    = empty ? '0 : mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are masked by empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 scan-byte parser: folds E0/F0 prefixes into key events
// and queues them in a small FIFO with flow control to the receiver.
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [7:0]      rx_data,
    output logic            rx_en,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_data,
    input  logic            ev_rd,
    output logic            overflow,
    output logic            seq_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_state_t      state;
    ps2_state_t      state_n;
    logic [TW-1:0]   tmo_cnt;
    logic            timeout;
    logic            is_ext;
    logic            is_brk;
    logic            push;
    logic [EV_W-1:0] push_data;
    logic            err_n;
    logic            empty;
    logic [CW-1:0]   count;
    logic            dropped;

    assign is_ext  = (rx_data == PFX_EXT);
    assign is_brk  = (rx_data == PFX_BRK);
    assign timeout = (state != ST_IDLE) &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Next-state, event push and error decode; a byte beats a timeout.
    always_comb begin
        state_n   = state;
        push      = 1'b0;
        push_data = '0;
        err_n     = 1'b0;
        if (rx_done_tick) begin
            state_n = ST_IDLE;
            unique case (state)
                ST_IDLE: begin
                    unique case (1'b1)
                        is_ext:  state_n = ST_EXT;
                        is_brk:  state_n = ST_BRK;
                        default: begin
                            push      = 1'b1;
                            push_data = make_ev(1'b0, 1'b0, rx_data);
                        end
                    endcase
                end
                ST_EXT: begin
                    unique case (1'b1)
                        is_brk:  state_n = ST_EXT_BRK;
                        is_ext:  err_n = 1'b1;
                        default: begin
                            push      = 1'b1;
                            push_data = make_ev(1'b1, 1'b0, rx_data);
                        end
                    endcase
                end
                ST_BRK: begin
                    if (is_ext || is_brk) begin
                        err_n = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = make_ev(1'b0, 1'b1, rx_data);
                    end
                end
                ST_EXT_BRK: begin
                    if (is_ext || is_brk) begin
                        err_n = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = make_ev(1'b1, 1'b1, rx_data);
                    end
                end
            endcase
        end else if (timeout) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Prefix timeout: restarts on every byte and whenever IDLE is next.
    always_ff @(posedge clk) begin
        if (!reset || rx_done_tick || state_n == ST_IDLE) tmo_cnt <= '0;
        else                                              tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Registered one-cycle error pulse and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            seq_err <= err_n;
            if (dropped) overflow <= 1'b1;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (ev_rd),
        .head      (ev_data),
        .empty     (empty),
        .count     (count),
        .dropped   (dropped)
    );

    assign ev_valid = !empty;
    assign rx_en    = (count <= CW'(FIFO_DEPTH - 2));

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed and randomized bench for ps2_key_controller against
// a queue-based model of prefix folding, FIFO and timeout rules.
module tb_ps2_key_controller;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_rd = 1'b0;
    logic       overflow;
    logic       seq_err;

    int n_chk  = 0;
    int n_fail = 0;
    string phase = "init";

    logic [9:0] mq[$];
    bit m_ext, m_rel, m_ovf, m_err;
    int m_wait;

    always #5 clk = ~clk;

    ps2_key_controller #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .ev_valid     (ev_valid),
        .ev_data      (ev_data),
        .ev_rd        (ev_rd),
        .overflow     (overflow),
        .seq_err      (seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $display("FAIL %s.%s: observed %0h expected %0h",
                     phase, tag, got, exp);
            $error("check %s.%s", phase, tag);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ext = 0; m_rel = 0; m_ovf = 0; m_err = 0; m_wait = 0;
    endtask

    task automatic model_push(input logic [9:0] ev);
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1;
    endtask

    // Effect of one clock edge given the inputs presented before it.
    task automatic model_edge(input bit tk, input logic [7:0] d,
                              input bit rd);
        bit pend;
        m_err = 0;
        if (rd && mq.size() > 0) void'(mq.pop_front());
        pend = m_ext || m_rel;
        if (tk) begin
            if (d == 8'hE0) begin
                if (!pend) begin m_ext = 1; m_wait = 0; end
                else begin m_err = 1; m_ext = 0; m_rel = 0; end
            end else if (d == 8'hF0) begin
                if (!m_rel) begin m_rel = 1; m_wait = 0; end
                else begin m_err = 1; m_ext = 0; m_rel = 0; end
            end else begin
                model_push({m_ext, m_rel, d});
                m_ext = 0; m_rel = 0;
            end
        end else if (pend) begin
            m_wait++;
            if (m_wait == TMO) begin
                m_err = 1; m_ext = 0; m_rel = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("ev_valid", ev_valid, mq.size() > 0);
        chk("ev_data",  ev_data,  mq.size() > 0 ? mq[0] : 10'h000);
        chk("rx_en",    rx_en,    mq.size() <= DEPTH - 2);
        chk("overflow", overflow, m_ovf);
        chk("seq_err",  seq_err,  m_err);
    endtask

    task automatic step(input bit tk, input logic [7:0] d, input bit rd);
        rx_done_tick = tk;
        rx_data      = d;
        ev_rd        = rd;
        model_edge(tk, d, rd);
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        ev_rd        = 1'b0;
        check_all();
    endtask

    task automatic send(input logic [7:0] d);
        step(1, d, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0);
    endtask

    task automatic pop();
        step(0, 8'h00, 1);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        ev_rd        = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        phase = "reset";
        @(posedge clk);
        do_reset();
        idle(2);

        phase = "make_break";
        send(8'h1C); send(8'hF0); send(8'h1C);
        chk("head0", ev_data, 10'h01C);
        pop();
        chk("head1", ev_data, 10'h11C);
        pop();

        phase = "extended";
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("head0", ev_data, 10'h275);
        pop();
        chk("head1", ev_data, 10'h375);
        pop();

        phase = "fill";
        send(8'h15); send(8'h16);
        chk("rx_en_2", rx_en, 1'b1);
        send(8'h17);
        chk("rx_en_3", rx_en, 1'b0);
        send(8'h18); send(8'h19);
        chk("ovf", overflow, 1'b1);
        chk("p0", ev_data, 10'h015); pop();
        chk("p1", ev_data, 10'h016); pop();
        chk("p2", ev_data, 10'h017); pop();
        chk("p3", ev_data, 10'h018); pop();
        chk("empty", ev_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);
        do_reset();

        phase = "timeout";
        send(8'hE0);
        idle(TMO - 1);
        chk("pre", seq_err, 1'b0);
        idle(1);
        chk("pulse", seq_err, 1'b1);
        idle(20 - TMO);
        send(8'h1C);
        chk("ev", ev_data, 10'h01C);
        pop();

        phase = "bad_prefix";
        send(8'hF0); send(8'hE0);
        chk("err", seq_err, 1'b1);
        chk("noev", ev_valid, 1'b0);
        send(8'h22);
        chk("idle_ev", ev_data, 10'h022);

        phase = "full_rw";
        send(8'h23); send(8'h24); send(8'h25);
        step(1, 8'h2A, 1);
        chk("ovf0", overflow, 1'b0);
        chk("head", ev_data, 10'h023);
        for (int i = 0; i < 4; i++) pop();
        chk("drained", ev_valid, 1'b0);

        phase = "one_rw";
        send(8'h31);
        step(1, 8'h32, 1);
        chk("head", ev_data, 10'h032);
        pop();

        phase = "mid_reset";
        send(8'h41); send(8'h42); send(8'hE0); send(8'hF0);
        do_reset();
        chk("valid", ev_valid, 1'b0);
        chk("rx_en", rx_en, 1'b1);
        chk("no_err", seq_err, 1'b0);
        send(8'h1C);
        chk("ev", ev_data, 10'h01C);
        pop();

        phase = "random";
        for (int it = 0; it < 3000; it++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else if (r < 4) begin
                idle($urandom_range(TMO - 2, TMO + 3));
            end else begin
                int s;
                s = $urandom_range(0, 99);
                if (s < 25)      b = 8'hE0;
                else if (s < 45) b = 8'hF0;
                else             b = 8'($urandom_range(0, 255));
                step($urandom_range(0, 99) < 45, b,
                     $urandom_range(0, 99) < 35);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
